// File: rtl/risc23_pkg.sv
// Shared types and defaults for the IITB-RISC-23 pipeline front end.
// Holds the fetch FSM encoding and the IF/ID payload layout.
package risc23_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    SKID
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] PC_INC_DEF   = 16'd2;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
  } ifid_t;

  // 16-bit add that wraps modulo 2^16, e.g. 16'hFFFE + 2 = 16'h0000.
  function automatic logic [15:0] pc_add(input logic [15:0] pc, input logic [15:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// Pipeline register carrying valid/instr/pc/pc2 with flush > hold > load priority.
// Without load, hold or flush it inserts a bubble and keeps the data fields.
module if_id_pipe_reg
  import risc23_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  hold,
  input  logic  load,
  input  ifid_t load_data,
  output logic  valid,
  output ifid_t data
);

  logic  valid_q;
  ifid_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (hold) begin
      valid_q <= valid_q;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch,
// squashes wrong-path fetches on EX redirect and parks one word in a skid on stall.
module if_stage
  import risc23_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc2
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [15:0]  addr_q, addr_d;
  logic         skid_valid_q, skid_valid_d;
  logic [15:0]  skid_instr_q, skid_instr_d;
  logic [15:0]  skid_pc_q, skid_pc_d;

  logic         pipe_flush;
  logic         pipe_hold;
  logic         pipe_load;
  ifid_t        pipe_data;
  ifid_t        ifid_data;

  // Redirect beats stall: whatever sits in IF/ID is younger than the branch.
  assign pipe_flush = redirect_en;
  assign pipe_hold  = stall && ifid_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    pipe_load    = 1'b0;
    pipe_data    = '{instr: imem_rdata, pc: addr_q, pc2: pc_add(addr_q, PC_INC)};

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        if (redirect_en) begin
          pc_d   = redirect_pc;
          addr_d = redirect_pc;
        end else begin
          addr_d = pc_q;
        end
      end

      REQ: begin
        if (imem_ack) begin
          if (redirect_en) begin
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end else if (!stall || !ifid_valid) begin
            pipe_load = 1'b1;
            pc_d      = pc_add(addr_q, PC_INC);
            addr_d    = pc_add(addr_q, PC_INC);
          end else begin
            // IF/ID is frozen: park the word and stop fetching until stall lifts.
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = addr_q;
            pc_d         = pc_add(addr_q, PC_INC);
            req_d        = 1'b0;
            state_d      = SKID;
          end
        end else if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = DROP;
        end
      end

      DROP: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          // Stale data is discarded; the newest redirect target goes out next.
          addr_d  = redirect_en ? redirect_pc : pc_q;
          state_d = REQ;
        end
      end

      SKID: begin
        if (redirect_en) begin
          skid_valid_d = 1'b0;
          pc_d         = redirect_pc;
          addr_d       = redirect_pc;
          req_d        = 1'b1;
          state_d      = REQ;
        end else if (!stall) begin
          pipe_load    = skid_valid_q;
          pipe_data    = '{instr: skid_instr_q, pc: skid_pc_q,
                           pc2: pc_add(skid_pc_q, PC_INC)};
          skid_valid_d = 1'b0;
          req_d        = 1'b1;
          addr_d       = pc_q;
          state_d      = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  if_id_pipe_reg u_if_id_pipe_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (pipe_flush),
    .hold      (pipe_hold),
    .load      (pipe_load),
    .load_data (pipe_data),
    .valid     (ifid_valid),
    .data      (ifid_data)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ifid_instr = ifid_data.instr;
  assign ifid_pc    = ifid_data.pc;
  assign ifid_pc2   = ifid_data.pc2;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the IITB-RISC-23 pipeline, and the receiving end of the EX-stage redirect interface (redirect_en/redirect_pc).
- Owns the PC and drives a req/ack instruction-memory port.
- Keeps at most one fetch outstanding.
- Feeds the IF/ID pipe register, including a 1-entry skid buffer.
- Squashes wrong-path fetches on redirect and honours the hazard-unit stall.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset.
PC_INC, 16'd2, byte increment per sequential fetch.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
redirect_en  in  1  from EX: taken branch/jump this cycle.
redirect_pc  in  16  from EX: target PC, valid when redirect_en=1.
stall  in  1  from hazard unit: hold the IF/ID contents.
imem_req  out  16-bit-addr request strobe, 1 bit; registered.
imem_addr  out  16  fetch address; registered; stable while imem_req=1.
imem_ack  in  1  memory returns imem_rdata this cycle; sampled only while imem_req=1.
imem_rdata  in  16  instruction word.
ifid_valid  out  1  IF/ID holds a live instruction.
ifid_instr  out  16  IF/ID instruction.
ifid_pc  out  16  IF/ID PC.
ifid_pc2  out  16  IF/ID PC+2, modulo 2^16.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, skid empty.
  - imem_req=0, imem_addr=0.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc2=0.
- Handshake:
  - Once imem_req=1, it stays 1 and imem_addr stays unchanged until a cycle with imem_ack=1.
  - Zero-wait ack (ack in the first req cycle) is legal.
  - After an ack, imem_req may stay high with a new address in the next cycle (back-to-back fetch).
- States: IDLE, REQ, DROP, SKID.
  - IDLE: always goes to REQ next cycle; imem_req<=1, imem_addr<=pc.
  - REQ, ack with redirect_en: discard imem_rdata; pc<=redirect_pc; imem_addr<=redirect_pc; stay REQ.
  - REQ, ack, no redirect, with (!stall or !ifid_valid): load IF/ID with {rdata, imem_addr, imem_addr+2}; pc<=imem_addr+2; imem_addr<=imem_addr+2; stay REQ.
  - REQ, ack, no redirect, with stall and ifid_valid: load skid with {rdata, addr}; pc<=addr+2; imem_req<=0; go to SKID.
  - REQ, no ack, with redirect_en: pc<=redirect_pc; go to DROP; req and addr unchanged.
  - REQ, no ack, no redirect: hold.
  - DROP: on ack, discard data; imem_addr<=pc; stay REQ-issuing (go to REQ). On a further redirect, pc<=redirect_pc (latest redirect wins); stay DROP. Both may happen in the same cycle: discard data and issue redirect_pc.
  - SKID, redirect_en: clear skid; pc<=redirect_pc; imem_req<=1, imem_addr<=redirect_pc; go to REQ.
  - SKID, !stall: move skid into IF/ID; imem_req<=1, imem_addr<=pc; go to REQ.
  - SKID, otherwise: hold.
- IF/ID update priority:
  - redirect_en forces ifid_valid<=0. Redirect beats stall, because the stalled instructions are younger.
  - Else stall with ifid_valid=1: hold all IF/ID fields.
  - Else load from the ack or the skid as above.
  - Otherwise ifid_valid<=0 (bubble); data fields keep their last value.
- Latency:
  - Redirect at cycle t with no fetch outstanding: imem_req with redirect_pc at t+1.
  - With zero-wait memory, ifid_valid for the target is seen at t+2.
  - With a fetch outstanding: the target is issued the cycle after the stale ack.
- Wrap-around: pc=16'hFFFE increments to 16'h0000, and ifid_pc2 wraps the same way.
- Odd redirect_pc is passed through unchanged; alignment is not checked.
- Reset assertion mid-fetch aborts the fetch immediately. The memory must tolerate a dropped request.

Decomposition:
- risc23_pkg (shared): fetch_state_t enum {IDLE, REQ, DROP, SKID}, RESET_PC default, PC_INC.
- Sub-module if_id_pipe_reg (valid/instr/pc/pc2 with load/hold/flush) is natural; it is reused by ID/EX-style registers.

Test Plan:
- Reset release, zero-wait memory returning 16'h1000+addr: imem_addr sequence 0,2,4,6 on consecutive cycles; ifid_pc trails by 1 cycle; ifid_pc2=ifid_pc+2.
- 3-cycle memory latency, redirect_pc=16'h0040 pulsed in the second wait cycle: imem_addr stays at the old value until ack; stale data is never valid in IF/ID; next req addr=16'h0040.
- stall=1 with ifid_valid=1 while an ack arrives for addr 8: imem_req drops; IF/ID holds; after stall=0, ifid_pc=8 the next cycle and the next req addr=10.
- Redirect and stall asserted together with a valid IF/ID: ifid_valid=0 next cycle; skid cleared; fetch from redirect_pc.
- Ack and redirect in the same cycle in REQ: data discarded; next imem_addr=redirect_pc.
- pc=16'hFFFE fetch: ifid_pc2=16'h0000; next imem_addr=16'h0000; rst_n low mid-wait clears imem_req and ifid_valid asynchronously.
